// File: rtl/src_pkg.sv
// Shared constants and types for the source-window read sequencer.
package src_pkg;

  localparam int IMG_W  = 28;
  localparam int IMG_H  = 28;
  localparam int K      = 3;
  localparam int ADDR_W = 12;
  localparam int TAP_W  = 4;
  localparam int POS_W  = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Identifies one issued read so it can be re-associated with qa later.
  typedef struct packed {
    logic             vld;
    logic [TAP_W-1:0] tap;
    logic [POS_W-1:0] row;
    logic [POS_W-1:0] col;
  } tag_t;

endpackage

// File: rtl/src_win_seq_rd_tag_pipe.sv
// Delay line matching the source-buffer read latency; carries the read tag
// alongside the data so the consumer sees tap/position aligned with qa.
module rd_tag_pipe
  import src_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic clk,
  input  logic rst,
  input  tag_t din,
  output tag_t dout,
  output logic empty
);

  tag_t stg [1:RD_LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= RD_LAT; i++) stg[i] <= '0;
    end else begin
      stg[1] <= din;
      for (int i = 2; i <= RD_LAT; i++) stg[i] <= stg[i-1];
    end
  end

  always_comb begin
    empty = 1'b1;
    for (int i = 1; i <= RD_LAT; i++)
      if (stg[i].vld) empty = 1'b0;
  end

  assign dout = stg[RD_LAT];

endmodule

// File: rtl/src_win_seq.sv
// Walks every KxK window of the source image, issuing one buffer read per
// cycle, and re-aligns each read's tap/position tag with the returned data.
module src_win_seq #(
  parameter int IMG_W  = src_pkg::IMG_W,
  parameter int IMG_H  = src_pkg::IMG_H,
  parameter int K      = src_pkg::K,
  parameter int RD_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stall,
  output logic        cena,
  output logic [11:0] aa,
  output logic        win_valid,
  output logic [3:0]  win_tap,
  output logic [4:0]  pos_row,
  output logic [4:0]  pos_col,
  output logic        last_tap,
  output logic        busy,
  output logic        done
);
  import src_pkg::*;

  localparam logic [ADDR_W-1:0] W_A    = ADDR_W'(IMG_W);
  localparam logic [POS_W-1:0]  C_LAST = POS_W'(IMG_W - K);
  localparam logic [POS_W-1:0]  R_LAST = POS_W'(IMG_H - K);
  localparam logic [TAP_W-1:0]  K_LAST = TAP_W'(K - 1);
  localparam logic [TAP_W-1:0]  T_LAST = TAP_W'(K*K - 1);

  state_t            state;
  logic [POS_W-1:0]  r, c;
  logic [TAP_W-1:0]  kr, kc, tap;
  // Running bases: row_base = r*W, pos_base = row_base+c, tap_row = pos_base+kr*W
  logic [ADDR_W-1:0] row_base, pos_base, tap_row;
  logic              issue, last_issue, pipe_empty;
  tag_t              tag_in, tag_out;

  assign issue      = (state == RUN) && !stall;
  assign last_issue = (r == R_LAST) && (c == C_LAST) && (kr == K_LAST) && (kc == K_LAST);
  assign cena       = ~(issue && !rst);

  always_comb begin
    tag_in = '0;
    if (issue) begin
      tag_in.vld = 1'b1;
      tag_in.tap = tap;
      tag_in.row = r;
      tag_in.col = c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      r        <= '0;
      c        <= '0;
      kr       <= '0;
      kc       <= '0;
      tap      <= '0;
      row_base <= '0;
      pos_base <= '0;
      tap_row  <= '0;
      aa       <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          state    <= RUN;
          busy     <= 1'b1;
          r        <= '0;
          c        <= '0;
          kr       <= '0;
          kc       <= '0;
          tap      <= '0;
          row_base <= '0;
          pos_base <= '0;
          tap_row  <= '0;
          aa       <= '0;
        end
        RUN: if (issue) begin
          if (last_issue) begin
            state <= DRAIN;
          end else if (kc != K_LAST) begin
            kc  <= kc + 1'b1;
            tap <= tap + 1'b1;
            aa  <= aa + 1'b1;
          end else if (kr != K_LAST) begin
            kc      <= '0;
            kr      <= kr + 1'b1;
            tap     <= tap + 1'b1;
            tap_row <= tap_row + W_A;
            aa      <= tap_row + W_A;
          end else if (c != C_LAST) begin
            kc       <= '0;
            kr       <= '0;
            tap      <= '0;
            c        <= c + 1'b1;
            pos_base <= pos_base + 1'b1;
            tap_row  <= pos_base + 1'b1;
            aa       <= pos_base + 1'b1;
          end else begin
            kc       <= '0;
            kr       <= '0;
            tap      <= '0;
            c        <= '0;
            r        <= r + 1'b1;
            row_base <= row_base + W_A;
            pos_base <= row_base + W_A;
            tap_row  <= row_base + W_A;
            aa       <= row_base + W_A;
          end
        end
        DRAIN: if (pipe_empty) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_pipe (
    .clk   (clk),
    .rst   (rst),
    .din   (tag_in),
    .dout  (tag_out),
    .empty (pipe_empty)
  );

  assign win_valid = tag_out.vld;
  assign win_tap   = tag_out.tap;
  assign pos_row   = tag_out.row;
  assign pos_col   = tag_out.col;
  assign last_tap  = tag_out.vld && (tag_out.tap == T_LAST);

endmodule

// File: tb/tb_src_win_seq.sv
// Randomized-stall bench for src_win_seq; expectations come from a direct
// index->(row,col,tap,addr) model and a latency scoreboard.
module tb_src_win_seq;
  localparam int W = 28, H = 28, KK = 3, LAT = 2;
  localparam int NPC = W - KK + 1, NPR = H - KK + 1, TAPS = KK * KK;
  localparam int TOTAL = NPC * NPR * TAPS;
  localparam int SW = 4, SNP = SW - KK + 1, STOTAL = SNP * SNP * TAPS;

  logic clk = 0, rst = 1, start = 0, stall = 0, start_s = 0;
  logic cena, win_valid, last_tap, busy, done;
  logic [11:0] aa;
  logic [3:0]  win_tap;
  logic [4:0]  pos_row, pos_col;
  logic cena_s, wv_s, lt_s, busy_s, done_s;
  logic [11:0] aa_s;
  logic [3:0]  tap_s;
  logic [4:0]  row_s, col_s;

  always #5 clk = ~clk;

  src_win_seq dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall), .cena(cena), .aa(aa),
    .win_valid(win_valid), .win_tap(win_tap), .pos_row(pos_row), .pos_col(pos_col),
    .last_tap(last_tap), .busy(busy), .done(done));

  src_win_seq #(.IMG_W(SW), .IMG_H(SW), .K(KK), .RD_LAT(LAT)) dut_s (
    .clk(clk), .rst(rst), .start(start_s), .stall(1'b0), .cena(cena_s), .aa(aa_s),
    .win_valid(wv_s), .win_tap(tap_s), .pos_row(row_s), .pos_col(col_s),
    .last_tap(lt_s), .busy(busy_s), .done(done_s));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Read #idx (0-based) of a run: window position idx/TAPS, tap idx%TAPS.
  function automatic int exp_addr(input int idx, input int w, input int np);
    int pos = idx / TAPS;
    int t   = idx % TAPS;
    return (pos / np + t / KK) * w + pos % np + t % KK;
  endfunction

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit mon_run = 0;
  int iss_idx = 0, n_valid = 0, n_last = 0, n_done = 0, last_aa = -1;
  int pend_cyc[$], pend_idx[$];
  int m_idx, m_cyc;
  bit exp_issue, exp_last;

  always @(negedge clk) begin
    if (!rst) begin
      exp_issue = mon_run && !stall && (iss_idx < TOTAL);
      chk("cena", int'(cena), int'(!exp_issue));
      if (mon_run && iss_idx < TOTAL) chk("aa", int'(aa), exp_addr(iss_idx, W, NPC));
      if (!cena) begin
        pend_cyc.push_back(cyc);
        pend_idx.push_back(iss_idx);
        last_aa = int'(aa);
        iss_idx++;
      end
      exp_last = 0;
      if (win_valid) begin
        if (pend_idx.size() == 0) chk("spurious_valid", 1, 0);
        else begin
          m_idx = pend_idx.pop_front();
          m_cyc = pend_cyc.pop_front();
          chk("latency", cyc - m_cyc, LAT);
          chk("win_tap", int'(win_tap), m_idx % TAPS);
          chk("pos_row", int'(pos_row), (m_idx / TAPS) / NPC);
          chk("pos_col", int'(pos_col), (m_idx / TAPS) % NPC);
          exp_last = (m_idx % TAPS) == TAPS - 1;
          n_valid++;
        end
      end
      chk("last_tap", int'(last_tap), int'(exp_last));
      if (last_tap) n_last++;
      if (done) begin
        n_done++;
        chk("done_drained", pend_idx.size(), 0);
        chk("done_all_issued", iss_idx, TOTAL);
      end
    end
  end

  int s_idx = 0, s_max = 0, s_done = 0;
  always @(negedge clk) begin
    if (!rst && !cena_s) begin
      chk("s_aa", int'(aa_s), exp_addr(s_idx, SW, SNP));
      if (int'(aa_s) > s_max) s_max = int'(aa_s);
      s_idx++;
    end
    if (!rst && done_s) s_done++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_cena"}, int'(cena), 1);
    chk({tag, "_aa"}, int'(aa), 0);
    chk({tag, "_valid"}, int'(win_valid), 0);
    chk({tag, "_tap"}, int'(win_tap), 0);
    chk({tag, "_row"}, int'(pos_row), 0);
    chk({tag, "_col"}, int'(pos_col), 0);
    chk({tag, "_last"}, int'(last_tap), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
  endtask

  task automatic clear_model();
    mon_run = 0; iss_idx = 0; n_valid = 0; n_last = 0; n_done = 0; last_aa = -1;
    pend_cyc.delete();
    pend_idx.delete();
  endtask

  task automatic begin_run();
    clear_model();
    start = 1;
    tick();
    start = 0;
    mon_run = 1;
  endtask

  task automatic wait_issues(input int target, input int bound, input bit rnd_stall);
    int n = 0;
    while (iss_idx < target && n < bound) begin
      if (rnd_stall) stall = ($urandom_range(0, 7) == 0);
      tick();
      n++;
    end
    stall = 0;
    if (iss_idx < target) chk("issue_timeout", iss_idx, target);
  endtask

  task automatic finish_run(input string tag);
    int n = 0;
    while (n_done == 0 && n < 50) begin tick(); n++; end
    repeat (3) tick();
    chk({tag, "_done_pulses"}, n_done, 1);
    chk({tag, "_valid_count"}, n_valid, TOTAL);
    chk({tag, "_last_count"}, n_last, NPC * NPR);
    chk({tag, "_final_aa"}, last_aa, W * H - 1);
    chk({tag, "_busy_end"}, int'(busy), 0);
    mon_run = 0;
  endtask

  initial begin
    int v0;
    rst = 1;
    repeat (3) tick();
    check_reset("rst_hold");
    rst = 0;
    tick();
    check_reset("idle");

    // Run A: first-issue timing, directed stall, ignored restart, random stalls.
    begin_run();
    chk("a_first_cena", int'(cena), 0);
    chk("a_first_aa", int'(aa), 0);
    chk("a_busy", int'(busy), 1);
    tick(); tick();
    chk("a_first_valid", int'(win_valid), 1);
    chk("a_first_tap", int'(win_tap), 0);
    chk("a_first_row", int'(pos_row), 0);
    chk("a_first_col", int'(pos_col), 0);
    wait_issues(10, 50, 0);
    stall = 1;
    v0 = n_valid;
    repeat (5) tick();
    chk("a_stall_inflight", n_valid - v0, 2);
    chk("a_stall_frozen", iss_idx, 10);
    stall = 0;
    repeat (20) tick();
    start = 1;
    tick();
    start = 0;
    wait_issues(TOTAL, 30000, 1);
    finish_run("a");

    // Run B: reset mid-run, then a clean full run.
    begin_run();
    wait_issues(500, 1000, 0);
    rst = 1;
    clear_model();
    tick();
    check_reset("midrun_rst");
    rst = 0;
    repeat (10) tick();
    chk("b_no_valid_after_rst", n_valid, 0);
    begin_run();
    chk("b_restart_aa", int'(aa), 0);
    chk("b_restart_cena", int'(cena), 0);
    wait_issues(TOTAL, 10000, 0);
    finish_run("b");

    // Run C: 4x4 image instance.
    start_s = 1;
    tick();
    start_s = 0;
    begin
      int n = 0;
      while (s_done == 0 && n < 200) begin tick(); n++; end
    end
    repeat (3) tick();
    chk("s_reads", s_idx, STOTAL);
    chk("s_max_aa", s_max, SW * SW - 1);
    chk("s_done", s_done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
